// File: rtl/cla_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// CLA_OVF_EN adds the registered signed-overflow flag ovf.
interface cla_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output x, y, cin, in_valid,
    input  sum, cout, out_valid
`ifdef CLA_OVF_EN
    , ovf
`endif
  );

  modport slave (
    input  x, y, cin, in_valid,
    output sum, cout, out_valid
`ifdef CLA_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/cla.sv
// Two-level carry-lookahead adder with one output register stage.
// CLA_OVF_EN adds a registered two's-complement overflow output.
module cla #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input logic clk,
  input logic rst_n,
  cla_if.slave bus
);
  localparam int NB = WIDTH / GROUP;

  logic [WIDTH-1:0] g, p, c;
  logic [NB-1:0]    bg, bp;
  logic [NB:0]      cb;

  assign g = bus.x & bus.y;
  assign p = bus.x ^ bus.y;

  always_comb begin : blk_gp
    logic t;
    t  = 1'b0;
    bg = '0;
    bp = '0;
    for (int b = 0; b < NB; b++) begin
      bp[b] = &p[b*GROUP +: GROUP];
      for (int j = 0; j < GROUP; j++) begin
        t = g[b*GROUP+j];
        for (int k = j + 1; k < GROUP; k++)
          t = t & p[b*GROUP+k];
        bg[b] = bg[b] | t;
      end
    end
  end

  // Every block carry-in is a flat sum of products over {G,P,cin}.
  always_comb begin : blk_carry
    logic t, acc;
    t   = 1'b0;
    acc = 1'b0;
    cb  = '0;
    cb[0] = bus.cin;
    for (int b = 0; b < NB; b++) begin
      acc = bus.cin;
      for (int a = 0; a <= b; a++)
        acc = acc & bp[a];
      for (int a = 0; a <= b; a++) begin
        t = bg[a];
        for (int k = a + 1; k <= b; k++)
          t = t & bp[k];
        acc = acc | t;
      end
      cb[b+1] = acc;
    end
  end

  always_comb begin : bit_carry
    logic t, acc;
    t   = 1'b0;
    acc = 1'b0;
    c   = '0;
    for (int b = 0; b < NB; b++) begin
      c[b*GROUP] = cb[b];
      for (int i = 0; i < GROUP - 1; i++) begin
        acc = cb[b];
        for (int k = 0; k <= i; k++)
          acc = acc & p[b*GROUP+k];
        for (int j = 0; j <= i; j++) begin
          t = g[b*GROUP+j];
          for (int k = j + 1; k <= i; k++)
            t = t & p[b*GROUP+k];
          acc = acc | t;
        end
        c[b*GROUP+i+1] = acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.out_valid <= 1'b0;
`ifdef CLA_OVF_EN
      bus.ovf       <= 1'b0;
`endif
    end else if (bus.in_valid) begin
      bus.sum       <= p ^ c;
      bus.cout      <= cb[NB];
      bus.out_valid <= 1'b1;
`ifdef CLA_OVF_EN
      bus.ovf       <= c[WIDTH-1] ^ cb[NB];
`endif
    end else begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cla.sv
// Scoreboard bench for cla: expected results queued on drive,
// popped and compared one cycle later.
module tb_cla;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cla_if #(.WIDTH(8)) bus ();

  cla #(.WIDTH(8), .GROUP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  logic [9:0] q[$];
  logic [9:0] held = '0;
  logic       pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum} from plain integer addition
  function automatic logic [9:0] model(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic ci);
    logic [8:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    v = (a[7] == b[7]) && (s[7] != a[7]);
    return {v, s};
  endfunction

  task automatic cyc(input logic v, input logic [7:0] a,
                     input logic [7:0] b, input logic ci);
    logic [9:0] e;
    @(posedge clk);
    #1;
    if (pend) begin
      e = q.pop_front();
      held = e;
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("sum_cout", 32'({bus.cout, bus.sum}), 32'(e[8:0]));
`ifdef CLA_OVF_EN
      chk("ovf", 32'(bus.ovf), 32'(e[9]));
`endif
    end else begin
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("hold", 32'({bus.cout, bus.sum}), 32'(held[8:0]));
    end
    bus.x = a;
    bus.y = b;
    bus.cin = ci;
    bus.in_valid = v;
    if (v) q.push_back(model(a, b, ci));
    pend = v;
  endtask

  initial begin
    bus.x = '0;
    bus.y = '0;
    bus.cin = 1'b0;
    bus.in_valid = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'({bus.cout, bus.sum}), 32'd0);
    #5 rst_n = 1'b1;

    cyc(1, 8'hFE, 8'h06, 1'b0);
    cyc(1, 8'hFF, 8'h00, 1'b1);
    chk("fe_06", 32'({bus.cout, bus.sum}), 32'h104);
    cyc(1, 8'h0F, 8'h01, 1'b0);
    chk("ff_00_c", 32'({bus.cout, bus.sum}), 32'h100);
    cyc(1, 8'h7F, 8'h01, 1'b0);
    chk("0f_01", 32'({bus.cout, bus.sum}), 32'h010);
    cyc(1, 8'hFF, 8'hFF, 1'b1);
    chk("7f_01", 32'({bus.cout, bus.sum}), 32'h080);
`ifdef CLA_OVF_EN
    chk("7f_01_ovf", 32'(bus.ovf), 32'd1);
`endif
    cyc(0, 8'hA5, 8'h5A, 1'b1);
    chk("ff_ff_c", 32'({bus.cout, bus.sum}), 32'h1FF);
    cyc(0, 8'h33, 8'hCC, 1'b0);
    cyc(1, 8'h80, 8'h80, 1'b0);
    cyc(1, 8'h12, 8'h34, 1'b0);
    cyc(0, 8'h00, 8'h00, 1'b0);

    // async reset between edges while a result is showing
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.out_valid), 32'd0);
    chk("async_sum", 32'({bus.cout, bus.sum}), 32'd0);
    #2 rst_n = 1'b1;
    q.delete();
    pend = 1'b0;
    held = '0;

    cyc(0, 8'h00, 8'h00, 1'b0);
    cyc(1, 8'h01, 8'h02, 1'b1);
    cyc(0, 8'h00, 8'h00, 1'b0);
    chk("post_rst", 32'({bus.cout, bus.sum}), 32'h004);

    for (int i = 0; i < 1000; i++)
      cyc(1, 8'($urandom), 8'($urandom), 1'($urandom));
    cyc(0, 8'h00, 8'h00, 1'b0);
    cyc(0, 8'h00, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/cla.md
Name: cla

Overview:
- Registered two-level carry-lookahead adder. Computes {cout, sum} = x + y + cin.
- Default width is 8 bits. Used as the fast add primitive inside the Goldschmidt divider datapath.
- Combinational lookahead logic feeds a single output register stage, so latency is one cycle.

Parameters:
- WIDTH, 8: operand and sum width in bits. Must be a positive multiple of GROUP.
- GROUP, 4: bits per first-level lookahead block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- x  input  WIDTH  operand A. Treated as a raw bit vector; the add is identical for signed and unsigned operands.
- y  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- in_valid  input  1  qualifies x/y/cin this cycle
- sum  output  WIDTH  registered sum bits
- cout  output  1  registered carry out of bit WIDTH-1
- out_valid  output  1  high for one cycle when sum/cout hold a new result

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, sum=0, cout=0 and out_valid=0, regardless of clk.
- Bit level: g[i]=x[i]&y[i] and p[i]=x[i]^y[i].
- First-level lookahead, per GROUP-bit block b:
  - internal carries use the expanded form c[i+1]=g[i] | p[i]g[i-1] | ... | p[i..base]c_in_b. Ripple chains are not allowed.
  - block generate G_b = g[top] | p[top]g[top-1] | ... | p[top..base+1]g[base].
  - block propagate P_b = AND of p[base..top].
- Second level: block carry-ins are computed from {G_b, P_b} and cin in expanded lookahead form.
  - c_in_0 = cin.
  - c_in_{b+1} = G_b | P_b & c_in_b, fully expanded.
- Result: sum_comb[i]=p[i]^c[i]; cout_comb = carry out of the last block.
- Register: on a rising clk edge with in_valid=1, sum<=sum_comb, cout<=cout_comb and out_valid<=1.
- On a rising edge with in_valid=0, sum and cout hold their previous values and out_valid<=0.
- Latency: exactly 1 cycle from in_valid to out_valid. Back-to-back valid inputs give back-to-back results, throughput 1 per cycle. No backpressure.
- Wrap-around: the sum is modulo 2^WIDTH and cout carries the overflow bit. For example, all-ones plus 1 gives sum=0, cout=1.
- cin=1 with x=y=all-ones gives sum=all-ones, cout=1.
- Reset asserted mid-stream clears the outputs immediately. The first valid input after rst_n deasserts produces out_valid one cycle later.
- Inputs are sampled only at the clock edge. Input changes between edges have no effect on the outputs.

Optional Feature:
- Macro CLA_OVF_EN.
- When defined:
  - adds output port ovf (1 bit), registered with the same enable and reset (0) as sum.
  - ovf = two's-complement signed overflow = c[WIDTH-1] ^ cout_comb.
- When undefined: port ovf does not exist and no overflow logic is built.

Test Plan:
- x=8'hFE, y=8'h06, cin=0, in_valid=1 -> next cycle sum=8'h04, cout=1, out_valid=1. With CLA_OVF_EN: ovf=0.
- x=8'hFF, y=8'h00, cin=1 -> sum=8'h00, cout=1. Then x=8'h0F, y=8'h01, cin=0 -> sum=8'h10, cout=0. This exercises the block-boundary carry.
- x=8'h7F, y=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1 when CLA_OVF_EN is defined.
- Hold check: with out_valid=1, set in_valid=0 and change x/y -> sum/cout unchanged and out_valid=0 on the next edge.
- Drive rst_n=0 asynchronously between clock edges while out_valid=1 -> sum=0, cout=0, out_valid=0 immediately.
- Randomised: 1000 random x, y, cin with in_valid=1 every cycle -> each {cout,sum} equals x+y+cin one cycle later.
